// File: rtl/sram_march_bist.sv
// sram_march_bist: parametrised March C- self-test engine for a synchronous SRAM.
//
// Runs the six March C- elements (w0; up r0w1; up r1w0; down r0w1; down r1w0; down r0) over
// all 2^ADDR_W words, using a background pattern selected at start. Read data is compared
// READ_LATENCY cycles after the read is issued through a matching shift register.
//
// Ports
//   Clock, Reset          clock, asynchronous active-high reset
//   BIST_start            rising edge in idle starts a run
//   BIST_mode             background: 0 solid, 1 checkerboard, 2 address, 3 as 0
//   BIST_abort            ends an active run on the next edge
//   BIST_address          registered SRAM address
//   BIST_write_data       registered SRAM write data
//   BIST_we_n             registered active-low write enable
//   BIST_read_data        SRAM read data, READ_LATENCY cycles after the address
//   BIST_finish           idle after a completed or aborted run
//   BIST_mismatch         sticky compare failure flag
//   BIST_fail_count       saturating compare failure count
//   BIST_fail_address/expected/actual  first failure log
module sram_march_bist #(
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              BIST_start,
    input  logic [1:0]        BIST_mode,
    input  logic              BIST_abort,
    output logic [ADDR_W-1:0] BIST_address,
    output logic [DATA_W-1:0] BIST_write_data,
    output logic              BIST_we_n,
    input  logic [DATA_W-1:0] BIST_read_data,
    output logic              BIST_finish,
    output logic              BIST_mismatch,
    output logic [15:0]       BIST_fail_count,
    output logic [ADDR_W-1:0] BIST_fail_address,
    output logic [DATA_W-1:0] BIST_fail_expected,
    output logic [DATA_W-1:0] BIST_fail_actual
);

    localparam int unsigned L = READ_LATENCY;
    localparam logic [ADDR_W-1:0] AddrLast = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [2:0]        elem_q, elem_d;      // march element 0..5
    logic              rd_q, rd_d;          // op currently driven is a read
    logic [3:0]        drain_q, drain_d;
    logic              start_q;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;    // during reads holds the expected data
    logic              we_n_q, we_n_d;
    logic              finish_q, finish_d;
    logic              mismatch_q, mismatch_d;
    logic [15:0]       fail_count_q, fail_count_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_act_q, fail_act_d;

    logic              pipe_vld_q [L];
    logic              pipe_vld_d [L];
    logic [DATA_W-1:0] pipe_exp_q [L];
    logic [DATA_W-1:0] pipe_exp_d [L];
    logic [ADDR_W-1:0] pipe_adr_q [L];
    logic [ADDR_W-1:0] pipe_adr_d [L];

    logic start_rise;
    assign start_rise = BIST_start & ~start_q;

    function automatic logic [DATA_W-1:0] background(input logic [1:0] mode,
                                                     input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] b;
        b = '0;
        case (mode)
            2'd1: begin
                for (int i = 0; i < DATA_W; i++) begin
                    b[i] = ((i % 2) == 0) ^ a[0];
                end
            end
            2'd2:    b = DATA_W'(a);
            default: b = '0;
        endcase
        return b;
    endfunction

    // Writes of M1/M3 and reads of M2/M4 use the inverted background.
    function automatic logic [DATA_W-1:0] op_data(input logic [1:0] mode, input logic [2:0] elem,
                                                  input logic is_write,
                                                  input logic [ADDR_W-1:0] a);
        logic inv;
        if (is_write) begin
            inv = (elem == 3'd1) || (elem == 3'd3);
        end else begin
            inv = (elem == 3'd2) || (elem == 3'd4);
        end
        return inv ? ~background(mode, a) : background(mode, a);
    endfunction

    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        rd_d         = rd_q;
        drain_d      = drain_q;
        mode_d       = mode_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_n_d       = we_n_q;
        finish_d     = finish_q;
        mismatch_d   = mismatch_q;
        fail_count_d = fail_count_q;
        fail_addr_d  = fail_addr_q;
        fail_exp_d   = fail_exp_q;
        fail_act_d   = fail_act_q;

        // Compare pipeline: entry k describes the read issued k+1 cycles ago.
        pipe_vld_d[0] = (state_q == StRun) && rd_q;
        pipe_exp_d[0] = wdata_q;
        pipe_adr_d[0] = addr_q;
        for (int k = 1; k < L; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_exp_d[k] = pipe_exp_q[k-1];
            pipe_adr_d[k] = pipe_adr_q[k-1];
        end

        if (pipe_vld_q[L-1] && (BIST_read_data != pipe_exp_q[L-1])) begin
            mismatch_d = 1'b1;
            if (fail_count_q != 16'hFFFF) begin
                fail_count_d = fail_count_q + 16'd1;
            end
            if (fail_count_q == 16'd0) begin
                fail_addr_d = pipe_adr_q[L-1];
                fail_exp_d  = pipe_exp_q[L-1];
                fail_act_d  = BIST_read_data;
            end
        end

        unique case (state_q)
            StIdle: begin
                addr_d   = '0;
                we_n_d   = 1'b1;
                wdata_d  = '0;
                finish_d = 1'b1;
                if (start_rise) begin
                    state_d      = StRun;
                    mode_d       = BIST_mode;
                    elem_d       = 3'd0;
                    rd_d         = 1'b0;
                    we_n_d       = 1'b0;
                    wdata_d      = background(BIST_mode, '0);
                    finish_d     = 1'b0;
                    mismatch_d   = 1'b0;
                    fail_count_d = '0;
                    fail_addr_d  = '0;
                    fail_exp_d   = '0;
                    fail_act_d   = '0;
                end
            end
            StRun: begin
                if (rd_q && (elem_q != 3'd5)) begin
                    // Second half of an r-then-w element: same address.
                    rd_d    = 1'b0;
                    we_n_d  = 1'b0;
                    wdata_d = op_data(mode_q, elem_q, 1'b1, addr_q);
                end else if (addr_q == ((elem_q < 3'd3) ? AddrLast : '0)) begin
                    if (elem_q == 3'd5) begin
                        state_d = StDrain;
                        drain_d = '0;
                        rd_d    = 1'b0;
                        addr_d  = '0;
                        we_n_d  = 1'b1;
                        wdata_d = '0;
                    end else begin
                        // Elements 1..5 all begin with a read.
                        elem_d  = elem_q + 3'd1;
                        addr_d  = (elem_d < 3'd3) ? '0 : AddrLast;
                        rd_d    = 1'b1;
                        we_n_d  = 1'b1;
                        wdata_d = op_data(mode_q, elem_d, 1'b0, addr_d);
                    end
                end else begin
                    addr_d  = (elem_q < 3'd3) ? addr_q + 1'b1 : addr_q - 1'b1;
                    rd_d    = (elem_q != 3'd0);
                    we_n_d  = (elem_q != 3'd0);
                    wdata_d = op_data(mode_q, elem_q, elem_q == 3'd0, addr_d);
                end
            end
            StDrain: begin
                if (drain_q == 4'(L - 1)) begin
                    state_d  = StIdle;
                    finish_d = 1'b1;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (BIST_abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            rd_d     = 1'b0;
            addr_d   = '0;
            we_n_d   = 1'b1;
            wdata_d  = '0;
            finish_d = 1'b1;
            for (int k = 0; k < L; k++) begin
                pipe_vld_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            elem_q       <= '0;
            rd_q         <= 1'b0;
            drain_q      <= '0;
            // A start held high through reset must not look like a fresh edge.
            start_q      <= 1'b1;
            mode_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_n_q       <= 1'b1;
            finish_q     <= 1'b0;
            mismatch_q   <= 1'b0;
            fail_count_q <= '0;
            fail_addr_q  <= '0;
            fail_exp_q   <= '0;
            fail_act_q   <= '0;
            for (int k = 0; k < L; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_exp_q[k] <= '0;
                pipe_adr_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            rd_q         <= rd_d;
            drain_q      <= drain_d;
            start_q      <= BIST_start;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_n_q       <= we_n_d;
            finish_q     <= finish_d;
            mismatch_q   <= mismatch_d;
            fail_count_q <= fail_count_d;
            fail_addr_q  <= fail_addr_d;
            fail_exp_q   <= fail_exp_d;
            fail_act_q   <= fail_act_d;
            for (int k = 0; k < L; k++) begin
                pipe_vld_q[k] <= pipe_vld_d[k];
                pipe_exp_q[k] <= pipe_exp_d[k];
                pipe_adr_q[k] <= pipe_adr_d[k];
            end
        end
    end

    assign BIST_address       = addr_q;
    assign BIST_write_data    = wdata_q;
    assign BIST_we_n          = we_n_q;
    assign BIST_finish        = finish_q;
    assign BIST_mismatch      = mismatch_q;
    assign BIST_fail_count    = fail_count_q;
    assign BIST_fail_address  = fail_addr_q;
    assign BIST_fail_expected = fail_exp_q;
    assign BIST_fail_actual   = fail_act_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two instances (read latency 2 and 3) share the control inputs,
// each with its own latency-matched SRAM model that can hold a stuck-at cell or invert all
// read data. Expected traces and failure logs come from a direct March C- walk.
module tb_sram_march_bist;

    localparam int N   = 16;
    localparam int Ops = 10 * N;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode  = 2'd0;

    logic [3:0]  addr  [2];
    logic [7:0]  wd    [2];
    logic        we_n  [2];
    logic [7:0]  rdata [2];
    logic        fin   [2];
    logic        mis   [2];
    logic [15:0] cnt   [2];
    logic [3:0]  faddr [2];
    logic [7:0]  fexp  [2];
    logic [7:0]  fact  [2];

    bit f_en    [2];
    int f_addr  [2];
    int f_bit   [2];
    bit f_val   [2];
    bit inv_all [2];
    int lat     [2] = '{2, 3};

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] tr_a  [Ops];
    bit         tr_rd [Ops];
    logic [7:0] tr_d  [Ops];

    int         m_cnt  [2];
    logic [3:0] m_addr [2];
    logic [7:0] m_exp  [2];
    logic [7:0] m_act  [2];

    always #5 clk = ~clk;

    function automatic logic [7:0] stored(input int g, input int a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (f_en[g] && a == f_addr[g]) r[f_bit[g]] = f_val[g];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int Lat = 2 + g;
        logic [7:0] mem  [16];
        logic [7:0] line [Lat];

        sram_march_bist #(
            .ADDR_W      (4),
            .DATA_W      (8),
            .READ_LATENCY(Lat)
        ) u_dut (
            .Clock             (clk),
            .Reset             (rst),
            .BIST_start        (start),
            .BIST_mode         (mode),
            .BIST_abort        (abort),
            .BIST_address      (addr[g]),
            .BIST_write_data   (wd[g]),
            .BIST_we_n         (we_n[g]),
            .BIST_read_data    (rdata[g]),
            .BIST_finish       (fin[g]),
            .BIST_mismatch     (mis[g]),
            .BIST_fail_count   (cnt[g]),
            .BIST_fail_address (faddr[g]),
            .BIST_fail_expected(fexp[g]),
            .BIST_fail_actual  (fact[g])
        );

        // Data of the address driven in cycle c appears during cycle c+Lat.
        always @(posedge clk) begin
            line[0] <= inv_all[g] ? ~mem[addr[g]] : mem[addr[g]];
            for (int k = 1; k < Lat; k++) line[k] <= line[k-1];
            if (!we_n[g]) mem[addr[g]] <= stored(g, int'(addr[g]), wd[g]);
        end
        assign rdata[g] = line[Lat-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bg(input logic [1:0] m, input int a);
        case (m)
            2'd1:    return (a % 2 == 0) ? 8'h55 : 8'hAA;
            2'd2:    return 8'(a);
            default: return 8'h00;
        endcase
    endfunction

    task automatic build_trace(input logic [1:0] m);
        int i = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                automatic int a = (e < 3) ? k : N - 1 - k;
                if (e != 0) begin
                    tr_a[i] = 4'(a); tr_rd[i] = 1'b1;
                    tr_d[i] = (e == 2 || e == 4) ? ~bg(m, a) : bg(m, a);
                    i++;
                end
                if (e != 5) begin
                    tr_a[i] = 4'(a); tr_rd[i] = 1'b0;
                    tr_d[i] = (e == 1 || e == 3) ? ~bg(m, a) : bg(m, a);
                    i++;
                end
            end
        end
    endtask

    // Reads whose compare lands before 'cutoff' are counted.
    task automatic model(input int cutoff);
        logic [7:0] ref_mem [16];
        logic [7:0] act;
        for (int g = 0; g < 2; g++) begin
            m_cnt[g] = 0; m_addr[g] = '0; m_exp[g] = '0; m_act[g] = '0;
            for (int i = 0; i < Ops; i++) begin
                if (!tr_rd[i]) begin
                    ref_mem[tr_a[i]] = stored(g, int'(tr_a[i]), tr_d[i]);
                end else begin
                    act = inv_all[g] ? ~ref_mem[tr_a[i]] : ref_mem[tr_a[i]];
                    if (act != tr_d[i] && (i + 1 + lat[g]) < cutoff) begin
                        if (m_cnt[g] == 0) begin
                            m_addr[g] = tr_a[i]; m_exp[g] = tr_d[i]; m_act[g] = act;
                        end
                        m_cnt[g]++;
                    end
                end
            end
        end
    endtask

    task automatic start_run(input logic [1:0] m);
        @(negedge clk); start = 1'b0; mode = m;
        @(negedge clk); start = 1'b1;
    endtask

    task automatic run_checked(input logic [1:0] m, input int abort_at, input int reset_at);
        build_trace(m);
        model(abort_at > 0 ? abort_at : 32'h4000_0000);
        start_run(m);
        for (int c = 1; c <= Ops + 4; c++) begin
            @(negedge clk);
            if (c == 3) mode = 2'($urandom_range(0, 3));
            if (c == 5 && reset_at == 0) start = 1'b0;
            if (abort_at > 0 && c == abort_at + 1) begin
                for (int g = 0; g < 2; g++)
                    check($sformatf("g%0d abort idle", g), {fin[g], we_n[g], addr[g]}, 6'b110000);
                abort = 1'b0;
                break;
            end
            if (c == reset_at) begin
                rst = 1'b1;
                #1;
                for (int g = 0; g < 2; g++) begin
                    check($sformatf("g%0d midrst outs", g),
                          {fin[g], mis[g], we_n[g], addr[g], wd[g], cnt[g]}, 31'h1 << 28);
                    check($sformatf("g%0d midrst log", g), {faddr[g], fexp[g], fact[g]}, 0);
                end
                @(negedge clk); rst = 1'b0;
                break;
            end
            for (int g = 0; g < 2; g++) begin
                automatic int fin_at = Ops + lat[g] + 1;
                if (c <= Ops) begin
                    check($sformatf("g%0d c%0d op", g, c),
                          {addr[g], we_n[g], tr_rd[c-1] ? 8'h00 : wd[g]},
                          {tr_a[c-1], tr_rd[c-1], tr_rd[c-1] ? 8'h00 : tr_d[c-1]});
                end else if (c >= fin_at) begin
                    check($sformatf("g%0d c%0d idle", g, c), {addr[g], we_n[g], wd[g]}, 13'h100);
                end
                check($sformatf("g%0d c%0d finish", g, c), 32'(fin[g]), 32'(c >= fin_at));
            end
            if (c == abort_at) abort = 1'b1;
        end
    endtask

    task automatic final_checks(input string name);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s g%0d mismatch", name, g), 32'(mis[g]), 32'(m_cnt[g] > 0));
            check($sformatf("%s g%0d count", name, g), 32'(cnt[g]), 32'(m_cnt[g]));
            check($sformatf("%s g%0d log", name, g), {faddr[g], fexp[g], fact[g]},
                  {m_addr[g], m_exp[g], m_act[g]});
        end
    endtask

    task automatic clear_faults();
        for (int g = 0; g < 2; g++) begin
            f_en[g] = 1'b0; f_addr[g] = 0; f_bit[g] = 0; f_val[g] = 1'b0; inv_all[g] = 1'b0;
        end
    endtask

    initial begin
        clear_faults();
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("g%0d reset outs", g),
                  {fin[g], mis[g], we_n[g], addr[g], wd[g], cnt[g]}, 31'h1 << 28);
            check($sformatf("g%0d reset log", g), {faddr[g], fexp[g], fact[g]}, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) check($sformatf("g%0d finish after rst", g), 32'(fin[g]), 1);

        run_checked(2'd0, 0, 0);
        final_checks("clean m0");

        for (int g = 0; g < 2; g++) begin
            f_en[g] = 1'b1; f_addr[g] = 5; f_bit[g] = 3; f_val[g] = 1'b0;
        end
        run_checked(2'd0, 0, 0);
        final_checks("sa0");
        check("sa0 count const", 32'(cnt[0]), 2);
        check("sa0 log const", {mis[0], faddr[0], fexp[0], fact[0]}, {1'b1, 4'd5, 8'hFF, 8'hF7});
        clear_faults();

        run_checked(2'd1, 0, 0);
        final_checks("clean m1");

        inv_all[1] = 1'b1;
        run_checked(2'd2, 0, 0);
        final_checks("inv m2");
        clear_faults();

        inv_all[0] = 1'b1;
        run_checked(2'd0, 50, 0);
        final_checks("abort");
        clear_faults();
        run_checked(2'd3, 0, 0);
        final_checks("after abort");

        run_checked(2'd1, 0, 30);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++)
                check($sformatf("g%0d held start %0d", g, i), {fin[g], we_n[g], addr[g]}, 6'b110000);
        end
        run_checked(2'd2, 0, 0);
        final_checks("after rst");

        for (int r = 0; r < 6; r++) begin
            for (int g = 0; g < 2; g++) begin
                f_en[g]    = 1'($urandom_range(0, 1));
                f_addr[g]  = $urandom_range(0, 15);
                f_bit[g]   = $urandom_range(0, 7);
                f_val[g]   = 1'($urandom_range(0, 1));
                inv_all[g] = ($urandom_range(0, 7) == 0);
            end
            run_checked(2'($urandom_range(0, 3)), 0, 0);
            final_checks($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
